// File: rtl/deinterleaver_if.sv
// ---------------------------------------------------------------------------
// deinterleaver_if
//   Bundles the serial bit-stream handshakes of the QPSK deinterleaver.
//   Signals:
//     blk_sel   block size code (0->24, 1->48, 2->96, 3->192, 4..7->384)
//     in_data   received hard bit, qualified by in_valid / in_ready
//     out_data  deinterleaved bit, qualified by out_valid / out_ready
//     out_last  marks the final bit of each output block
//   Modports:
//     master  the environment: drives the input stream, accepts the output
//     slave   the deinterleaver itself
// ---------------------------------------------------------------------------
interface deinterleaver_if;
    logic [2:0] blk_sel;
    logic       in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output blk_sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  blk_sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/deinterleaver.sv
// ---------------------------------------------------------------------------
// deinterleaver
//   WiMAX OFDM receive-side bit deinterleaver for QPSK (Ncpc = 2, s = 1),
//   Ncbps = 24/48/96/192/384. Bits arrive serially in interleaved order and
//   leave serially in original order: output bit k is input bit
//   m_k = (Ncbps/12)*(k mod 12) + floor(k/12) of the same block.
//   Two ping-pong banks let one block fill while the other drains.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low reset
//     bus    deinterleaver_if.slave (input stream, output stream, blk_sel)
// ---------------------------------------------------------------------------
module deinterleaver #(
    parameter int MAX_NCBPS = 384
) (
    input  logic              clk,
    input  logic              reset,
    deinterleaver_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Codes above 4 all mean the 384-bit block.
    function automatic logic [2:0] clamp_code(input logic [2:0] sel);
        return (sel > 3'd4) ? 3'd4 : sel;
    endfunction

    // Ncbps - 1 = 24 * 2^code - 1
    function automatic logic [8:0] last_index(input logic [2:0] code);
        return (9'd24 << code) - 9'd1;
    endfunction

    // Ncbps / 12 = 2 * 2^code, the address stride down one column
    function automatic logic [8:0] col_step(input logic [2:0] code);
        return 9'd2 << code;
    endfunction

    logic [MAX_NCBPS-1:0] bank_q [2];
    logic [MAX_NCBPS-1:0] bank_d [2];
    logic [2:0]           ncode_q [2];
    logic [2:0]           ncode_d [2];
    logic [1:0]           full_q, full_d, full_set, full_clr;

    logic                 wr_bank_q, wr_bank_d;
    logic [8:0]           wr_addr_q, wr_addr_d;
    logic [2:0]           wr_code;
    logic                 wr_fire;
    logic                 in_ready_w;

    state_t               state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 other_bank;
    logic [8:0]           rd_addr_q, rd_addr_d;
    logic [8:0]           next_addr;
    logic [8:0]           k_q, k_d;
    logic [3:0]           r_q, r_d;
    logic [4:0]           c_q, c_d;
    logic [2:0]           rd_code;
    logic                 out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    // The write side may only target a bank that is not holding a block.
    assign in_ready_w    = reset & ~full_q[wr_bank_q];
    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    assign full_d = (full_q | full_set) & ~full_clr;

    // Write side: store each accepted bit in natural order. The block size
    // comes from blk_sel on the first bit and from the latched code after.
    always_comb begin
        bank_d    = bank_q;
        ncode_d   = ncode_q;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        full_set  = 2'b00;
        wr_fire   = bus.in_valid & in_ready_w;
        wr_code   = (wr_addr_q == 9'd0) ? clamp_code(bus.blk_sel) : ncode_q[wr_bank_q];

        if (wr_fire) begin
            bank_d[wr_bank_q][wr_addr_q] = bus.in_data;
            ncode_d[wr_bank_q]           = wr_code;
            if (wr_addr_q == last_index(wr_code)) begin
                full_set[wr_bank_q] = 1'b1;
                wr_addr_d           = 9'd0;
                wr_bank_d           = ~wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + 9'd1;
            end
        end
    end

    // Read side: walk the bank row by row of the 12-row matrix. Within a
    // column the address strides by Ncbps/12; at row 11 it wraps to the top
    // of the next column. The output register is loaded with the next bit on
    // every transfer, so the first bit of a newly full bank is loaded on the
    // IDLE->DRAIN step or directly at the end of the previous block.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        k_d         = k_q;
        r_d         = r_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        full_clr    = 2'b00;
        next_addr   = rd_addr_q;
        other_bank  = ~rd_bank_q;
        rd_code     = ncode_q[rd_bank_q];

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = DRAIN;
                    rd_addr_d   = 9'd0;
                    k_d         = 9'd0;
                    r_d         = 4'd0;
                    c_d         = 5'd0;
                    out_data_d  = bank_q[rd_bank_q][9'd0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (k_q == last_index(rd_code)) begin
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = other_bank;
                        rd_addr_d           = 9'd0;
                        k_d                 = 9'd0;
                        r_d                 = 4'd0;
                        c_d                 = 5'd0;
                        out_last_d          = 1'b0;
                        if (full_q[other_bank]) begin
                            out_data_d  = bank_q[other_bank][9'd0];
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            out_data_d  = 1'b0;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        if (r_q < 4'd11) begin
                            next_addr = rd_addr_q + col_step(rd_code);
                            r_d       = r_q + 4'd1;
                        end else begin
                            next_addr = {4'd0, c_q + 5'd1};
                            r_d       = 4'd0;
                            c_d       = c_q + 5'd1;
                        end
                        rd_addr_d  = next_addr;
                        k_d        = k_q + 9'd1;
                        out_data_d = bank_q[rd_bank_q][next_addr];
                        out_last_d = ((k_q + 9'd1) == last_index(rd_code));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset discards any stored block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q      <= 2'b00;
            ncode_q[0]  <= 3'd0;
            ncode_q[1]  <= 3'd0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= 9'd0;
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= 9'd0;
            k_q         <= 9'd0;
            r_q         <= 4'd0;
            c_q         <= 5'd0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            ncode_q     <= ncode_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Bank contents need no reset: a bank is only read once marked full.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: doc/deinterleaver.md
# deinterleaver

Receive-side WiMAX OFDM bit deinterleaver for QPSK (Ncpc = 2, s = 1), covering Ncbps = 24, 48, 96, 192 and 384. It sits between the demapper and the decoder, and undoes the transmit interleaver's first permutation, m_k = (Ncbps/12)·(k mod 12) + floor(k/12). For s = 1 the second permutation is the identity. Bits stream in serially in interleaved order and leave serially in original order. A ping-pong pair of block buffers lets one block fill while the previous one drains.

## Interface
- MAX_NCBPS, 384, depth of each bank in bits; must be 384
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low; reset = 0 at a rising edge resets the block
- blk_sel  in  3  block size code: 0→24, 1→48, 2→96, 3→192, 4→384; codes 5–7 are treated as 4
- in_data  in  1  received hard bit
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a bit; a bit transfers when in_valid & in_ready are high at an edge
- out_data  out  1  deinterleaved bit
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts; a bit transfers when out_valid & out_ready are high at an edge
- out_last  out  1  high with the final bit (k = Ncbps−1) of each block

## Operation
- Storage: two banks of MAX_NCBPS bits (bank 0, bank 1), plus per bank a full flag and a latched Ncbps.
- Write side:
  - Holds wr_bank and wr_addr.
  - blk_sel is sampled into the bank's Ncbps on the block's first accepted bit (wr_addr = 0). Changes to blk_sel mid-block are ignored.
  - Each accepted bit writes bank[wr_bank][wr_addr], then wr_addr increments.
  - When wr_addr = Ncbps−1 is accepted: full[wr_bank] sets, wr_addr returns to 0, wr_bank toggles.
- in_ready = reset & ~full[wr_bank]. It is combinational from registers, not from in_valid.
- Read side: holds rd_bank, k counter, row r (0..11), col c, and rd_addr.
  - States: IDLE (full[rd_bank] = 0) and DRAIN.
  - On entering DRAIN: rd_addr = 0, r = 0, c = 0.
  - Address step per output bit: if r < 11, then rd_addr += Ncbps/12 and r += 1; else r = 0, c += 1, rd_addr = c + 1. No multiplier is used.
  - Ncbps/12 is 2, 4, 8, 16 or 32, so the step is a shift.
  - out_data = bank[rd_bank][rd_addr], presented through an output register.
  - After the bit with k = Ncbps−1 transfers: full[rd_bank] clears, rd_bank toggles, and the state returns to IDLE, or goes straight to DRAIN if the other bank is already full.
- Net mapping: output bit k equals input bit j = m_k of the same block.
- Address widths: wr_addr and rd_addr are 9 bits, k is 9 bits, c is 5 bits, r is 4 bits.
- Simultaneous fill and drain:
  - A bank being cleared by the read side and set by the write side in the same cycle cannot occur, because the write side only targets a bank whose full flag is 0.
  - Clearing full[rd_bank] in cycle T makes in_ready high in T+1 if the write side is waiting on that bank.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, in_ready = 0 while reset = 0.
  - Both full flags = 0, wr_bank = rd_bank = 0, all counters = 0, state = IDLE.
  - in_ready = 1 in the first cycle after reset = 1.
- Reset mid-operation: any partial or full block is discarded, with no output of stale bits.
- Latency: last input bit accepted at edge T → full set after T → out_valid = 1 with k = 0 after edge T+1, so the first output appears 2 cycles after the last input.
- Output hold: out_valid/out_data/out_last are held stable while out_valid & ~out_ready.
- Throughput: 1 bit/cycle sustained on both sides with out_ready = 1. There are no bubbles between consecutive blocks when the next bank is full.
- Backpressure:
  - With both banks full, in_ready = 0 until the drain of the older bank completes.
  - out_valid drops only after the last bit transfers and no full bank is pending.

## Test plan
- Reset, then a 24-bit block, blk_sel = 0, one-hot at j = 2 → output bit k = 1 is 1, all others 0; out_last on k = 23; first out_valid 2 cycles after the 24th input.
- Same stimulus with one-hot at j = 1 → k = 12 is 1; j = 23 → k = 23 is 1.
- blk_sel = 4, input j = 0..383 carrying a counter pattern, checked by the scoreboard against the m_k formula → all 384 outputs match; blk_sel toggled to 0 mid-block has no effect.
- Three back-to-back 96-bit blocks with out_ready = 0 → in_ready falls after the 192nd bit; releasing out_ready → 288 correct bits, zero-bubble transition between blocks.
- Random out_ready (50%) over 20 blocks of mixed size → data held stable during stalls, ordering and out_last correct.
- reset = 0 for one cycle in the middle of the second block of a drain → out_valid = 0 the next cycle, in_ready = 1 the cycle after release, and a subsequent 48-bit block deinterleaves correctly.
